// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
package mem_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Bit positions of the error-cause vector built at request acceptance.
   localparam int ERR_RW_BOTH  = 0;
   localparam int ERR_MISALIGN = 1;
   localparam int ERR_RANGE    = 2;
   localparam int ERR_CAUSES   = 3;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous word RAM with registered read port
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // Array contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   dout <= '0;
      else if (re) dout <= mem[idx];
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated memory responder for the multicycle controller
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int AW          = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q;
   logic                op_rd_q, op_wr_q, bad_q;
   logic [AW-1:0]       idx_q;
   logic [WORD_W-1:0]   wdata_q;
   logic                ready_q, err_q;
   logic                ram_we, ram_re;
   logic [ERR_CAUSES-1:0] cause;

   always_comb begin
      cause               = '0;
      cause[ERR_RW_BOTH]  = memread & memwrite;
      cause[ERR_MISALIGN] = |addr[1:0];
      cause[ERR_RANGE]    = |addr[WORD_W-1:AW+2];
   end

   always_comb begin
      state_d = state_q;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      case (state_q)
         IDLE: begin
            if (memread | memwrite)
               state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
         end
         WAIT: begin
            if (cnt_q <= 4'd1) state_d = ACCESS;
         end
         ACCESS: begin
            ram_we  = op_wr_q & ~bad_q;
            ram_re  = op_rd_q & ~bad_q;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_rd_q <= 1'b0;
         op_wr_q <= 1'b0;
         bad_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (memread | memwrite) begin
                  op_rd_q <= memread;
                  op_wr_q <= memwrite;
                  bad_q   <= |cause;
                  idx_q   <= addr[AW+1:2];
                  wdata_q <= wdata;
                  cnt_q   <= WAIT_LD;
               end
            end
            WAIT: cnt_q <= cnt_q - 4'd1;
            ACCESS: begin
               ready_q <= 1'b1;
               err_q   <= bad_q;
            end
            default: ;
         endcase
      end
   end

   // rdata is the RAM read register itself, so it only moves on a good read.
   mem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk  (clk),
      .reset(reset),
      .we   (ram_we),
      .re   (ram_re),
      .idx  (idx_q),
      .din  (wdata_q),
      .dout (rdata)
   );

   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = (state_q == WAIT) || (state_q == ACCESS);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at two wait-state settings
module tb_mem_responder;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread  [2];
   logic        memwrite [2];
   logic [31:0] addr     [2];
   logic [31:0] wdata    [2];
   logic [31:0] rdata    [2];
   logic        ready    [2];
   logic        busy     [2];
   logic        err      [2];

   sb_t         q [2][$];
   logic [31:0] model   [2][1024];
   logic [31:0] last_rd [2];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .AW(10)) dut_w2 (
      .clk(clk), .reset(reset), .memread(memread[0]), .memwrite(memwrite[0]),
      .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
      .busy(busy[0]), .err(err[0])
   );

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .AW(10)) dut_w0 (
      .clk(clk), .reset(reset), .memread(memread[1]), .memwrite(memwrite[1]),
      .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
      .busy(busy[1]), .err(err[1])
   );

   function automatic int wc(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ready[d] === 1'b1) begin
            if (q[d].size() == 0) begin
               check("unexpected_ready", 1, 0);
            end else begin
               sb_t e;
               e = q[d].pop_front();
               check("err", {31'd0, err[d]}, {31'd0, e.err});
               check("rdata", rdata[d], e.data);
            end
         end else if (err[d] === 1'b1) begin
            check("err_without_ready", 1, 0);
         end
      end
   end

   function automatic sb_t predict(input int d, input logic rd, input logic wr,
                                   input logic [31:0] a, input logic [31:0] wd);
      sb_t e;
      logic bad;
      bad = (rd && wr) || (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
      if (!bad && wr) model[d][a[11:2]] = wd;
      if (!bad && rd) last_rd[d] = model[d][a[11:2]];
      e.err  = bad;
      e.data = last_rd[d];
      return e;
   endfunction

   // Called at a negedge with the responder idle; returns at a negedge in IDLE.
   task automatic do_req(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
      int n;
      int busy_n;
      q[d].push_back(predict(d, rd, wr, a, wd));
      memread[d] = rd; memwrite[d] = wr; addr[d] = a; wdata[d] = wd;
      n = 0; busy_n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (busy[d]) busy_n++;
         if (ready[d]) break;
      end
      check("latency", n, wc(d) + 2);
      check("busy_cycles", busy_n, wc(d) + 1);
      memread[d] = 1'b0; memwrite[d] = 1'b0;
      @(negedge clk);
   endtask

   // Request level held across RESP: the second ready follows the first by WAIT_CYCLES+3.
   task automatic back_to_back(input int d, input logic [31:0] a);
      int n;
      q[d].push_back(predict(d, 1'b1, 1'b0, a, 32'd0));
      q[d].push_back(predict(d, 1'b1, 1'b0, a, 32'd0));
      memread[d] = 1'b1; memwrite[d] = 1'b0; addr[d] = a;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (ready[d]) break;
      end
      check("b2b_first", n, wc(d) + 2);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (ready[d]) break;
      end
      check("b2b_gap", n, wc(d) + 3);
      memread[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         memread[d] = 1'b0; memwrite[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
         last_rd[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_rdata", rdata[d], 0);
         check("reset_ready", {31'd0, ready[d]}, 0);
         check("reset_busy",  {31'd0, busy[d]}, 0);
         check("reset_err",   {31'd0, err[d]}, 0);
      end
      reset = 1'b0;
      @(negedge clk);

      do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);

      do_req(1, 1'b0, 1'b1, 32'h0, 32'h12345678);
      do_req(1, 1'b1, 1'b0, 32'h0, 32'h0);

      do_req(0, 1'b0, 1'b1, 32'h13, 32'h0BADF00D);
      do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
      do_req(0, 1'b0, 1'b1, 32'h20, 32'h01020304);
      do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
      do_req(0, 1'b1, 1'b1, 32'h20, 32'hFFFF0000);
      do_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
      do_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
      do_req(1, 1'b1, 1'b0, 32'h2, 32'h0);

      do_req(0, 1'b0, 1'b1, 32'h40, 32'h11111111);
      memwrite[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hAAAA5555;
      repeat (2) @(negedge clk);
      check("mid_wait_busy", {31'd0, busy[0]}, 1);
      reset = 1'b1;
      @(negedge clk);
      check("in_reset_rdata", rdata[0], 0);
      check("in_reset_ready", {31'd0, ready[0]}, 0);
      check("in_reset_busy",  {31'd0, busy[0]}, 0);
      check("in_reset_err",   {31'd0, err[0]}, 0);
      memwrite[0] = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready[0]) pulses++;
      end
      check("aborted_ready_pulses", pulses, 0);
      do_req(0, 1'b1, 1'b0, 32'h40, 32'h0);

      back_to_back(0, 32'h10);
      back_to_back(1, 32'h0);

      repeat (4) @(negedge clk);
      check("sb_empty_w2", q[0].size(), 0);
      check("sb_empty_w0", q[1].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle controller's memory request interface: memread, memwrite, and an address already selected by IorD.
- Serves instruction fetch and data load/store from one unified word-addressed RAM.
- Adds a configurable wait-state latency and returns a one-cycle ready pulse, so the controller can stall in its fetch and memory-access states.
- Sits between the datapath address/write-data mux and the instruction/data registers.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM; power of two.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and completion; legal range 0..15.
- AW, 10: word-index width; equals log2(DEPTH_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- memread  in  1  read request level from the controller.
- memwrite  in  1  write request level from the controller.
- addr  in  32  byte address; word index is addr[AW+1:2].
- wdata  in  32  store data, sampled when a write is accepted.
- rdata  out  32  registered read data.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight.
- err  out  1  one-cycle error pulse, coincident with ready.

Behaviour:
- Reset values: rdata=0, ready=0, busy=0, err=0, state=IDLE, wait counter=0. The RAM array is not cleared.
- Reset asserted mid-operation aborts the request. A pending write is not performed. After reset releases, the FSM returns to IDLE.
- States:
  - IDLE: busy=0. On a rising edge with memread|memwrite=1, the block latches addr, wdata and the operation, loads the counter with WAIT_CYCLES, and goes to WAIT, or to ACCESS if WAIT_CYCLES=0. No request: stays in IDLE.
  - WAIT: busy=1. The counter decrements each edge. When the counter reaches 1, the next state is ACCESS. Request inputs are ignored; the latched copies are used.
  - ACCESS: busy=1. On this edge:
    - a write updates the RAM word with the latched wdata;
    - a read loads rdata from the RAM at the latched index;
    - ready=1 is registered for the following cycle, and the FSM goes to RESP.
  - RESP: ready=1, busy=0, err valid. The next edge returns to IDLE. A request present during RESP is not accepted; it is accepted on the IDLE edge that follows.
- Latency: a request accepted at edge k produces ready high in the cycle after edge k+WAIT_CYCLES+1. With WAIT_CYCLES=0, ready is high two cycles after the request is first seen.
- rdata holds its value until the next successful read. Writes and error responses leave rdata unchanged.
- Error conditions: any of the following gives err=1 together with ready, and no RAM or rdata change.
  - memread=1 and memwrite=1 in the same accepting cycle.
  - addr[1:0]!=0 (misaligned address).
  - addr[31:AW+2]!=0 (address out of range).
- Error requests still take the full wait latency.
- The controller holds its request level until ready; the responder never accepts two requests back to back without passing through RESP.

Decomposition:
- Shared package mem_pkg:
  - state enum IDLE/WAIT/ACCESS/RESP;
  - WORD_W=32;
  - the error-cause localparams.
- One sub-module: mem_array, a single-port synchronous RAM with we, idx, din and dout. The responder holds only the FSM, the counter and the latches.

Test Plan:
- Reset, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10, then read 0x10 → each ready pulse arrives 3 cycles after acceptance; rdata=0xDEADBEEF.
- WAIT_CYCLES=0: read of preloaded word 0x12345678 at addr 0x0 → ready two cycles after the request; busy high for exactly one cycle.
- addr=0x13 with memwrite=1 → err=1 with ready; a following read of 0x10 returns the old value.
- memread=memwrite=1 at addr 0x20 → err pulse; RAM word 0x20 is unchanged and rdata keeps its previous value.
- Assert reset during WAIT of a write of 0xAAAA5555 to 0x40 → ready never pulses; a later read of 0x40 returns the pre-write value; outputs are 0 during reset.
- Request held high across RESP → second ready arrives exactly WAIT_CYCLES+3 cycles after the first.
